// File: rtl/kd_pkg.sv
// Shared types, sizes and tree helpers for the kd-tree sort sequencer.
package kd_pkg;

    localparam int unsigned DIM        = 3;
    localparam int unsigned DATA_RANGE = 255;
    localparam int unsigned LEVELS     = 3;
    localparam int unsigned CW         = $clog2(DATA_RANGE);

    function automatic int unsigned center_w(input int unsigned dim);
        return dim * CW;
    endfunction

    function automatic int unsigned nodes_of(input int unsigned lv);
        return (32'd1 << lv) - 32'd1;
    endfunction

    function automatic int unsigned internal_of(input int unsigned lv);
        return (32'd1 << (lv - 32'd1)) - 32'd1;
    endfunction

    localparam int unsigned NODES    = nodes_of(LEVELS);
    localparam int unsigned INTERNAL = internal_of(LEVELS);
    localparam int unsigned IW       = $clog2(NODES);
    localparam int unsigned AW       = $clog2(DIM);
    localparam int unsigned CEN_W    = center_w(DIM);

    typedef logic [DIM-1:0][CW-1:0] center_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXCH,
        ST_CHECK,
        ST_DONE
    } state_e;

    function automatic int unsigned depth(input int unsigned i);
        int unsigned n;
        int unsigned d;
        n = i;
        d = 0;
        for (int unsigned k = 0; k < 32; k++) begin
            if (n != 0) begin
                n = (n - 32'd1) / 32'd2;
                d = d + 32'd1;
            end
        end
        return d;
    endfunction

    // Sweep position k -> node index: even-depth nodes ascending, then odd-depth.
    function automatic int unsigned sweep_node(input int unsigned k);
        int unsigned cnt;
        int unsigned res;
        cnt = 0;
        res = 0;
        for (int unsigned par = 0; par < 2; par++) begin
            for (int unsigned i = 0; i < INTERNAL; i++) begin
                if ((depth(i) % 32'd2) == par) begin
                    if (cnt == k) res = i;
                    cnt = cnt + 32'd1;
                end
            end
        end
        return res;
    endfunction

    function automatic int unsigned sweep_axis(input int unsigned k);
        return depth(sweep_node(k)) % DIM;
    endfunction

endpackage

// File: rtl/kd_sort_if.sv
// Load / read / status bus between the kd-tree sorter and its neighbours.
interface kd_sort_if;
    import kd_pkg::*;

    logic                 load_en;
    logic [IW-1:0]        load_idx;
    logic [CEN_W-1:0]     load_data;
    logic                 start;
    logic [IW-1:0]        rd_idx;
    logic [CEN_W-1:0]     rd_data;
    logic                 busy;
    logic                 done;
    logic [7:0]           pass_cnt;
    logic [15:0]          swap_cnt;
    logic                 timeout;

    modport master (
        output load_en, load_idx, load_data, start, rd_idx,
        input  rd_data, busy, done, pass_cnt, swap_cnt, timeout
    );

    modport slave (
        input  load_en, load_idx, load_data, start, rd_idx,
        output rd_data, busy, done, pass_cnt, swap_cnt, timeout
    );
endinterface

// File: rtl/kd_cmp3.sv
// Stable three-way ascending ordering of (left, parent, right) on one axis.
module kd_cmp3
    import kd_pkg::*;
(
    input  logic [AW-1:0] axis,
    input  center_t       l,
    input  center_t       p,
    input  center_t       r,
    output center_t       l_c,
    output center_t       p_c,
    output center_t       r_c,
    output logic          changed_c
);

    center_t a_c, b_c, c_c;

    // Strict-compare bubble network: equal keys never cross, so the order is stable.
    always_comb begin
        a_c = l;
        b_c = p;
        c_c = r;
        if (a_c[axis] > b_c[axis]) {a_c, b_c} = {b_c, a_c};
        if (b_c[axis] > c_c[axis]) {b_c, c_c} = {c_c, b_c};
        if (a_c[axis] > b_c[axis]) {a_c, b_c} = {b_c, a_c};
        l_c       = a_c;
        p_c       = b_c;
        r_c       = c_c;
        changed_c = (a_c != l) || (b_c != p) || (c_c != r);
    end

endmodule

// File: rtl/kd_sort_sched.sv
// Sweeps one shared compare-exchange unit over the kd-tree until a sweep makes no swap.
// KD_SORT_TIMEOUT_EN: stop after MAX_PASSES dirty sweeps and flag timeout.
module kd_sort_sched
    import kd_pkg::*;
#(
    parameter int unsigned MAX_PASSES = 16
)
(
    input  logic         clk,
    input  logic         rst,
    kd_sort_if.slave     bus
);

`ifdef KD_SORT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    state_e        state_q, state_d;
    center_t       nodes_q [NODES];
    center_t       nodes_d [NODES];
    logic [IW-1:0] step_q, step_d;
    logic [IW-1:0] par_q, par_d;
    logic [AW-1:0] axis_q, axis_d;
    logic          dirty_q, dirty_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    pass_cnt_q, pass_cnt_d;
    logic [15:0]   swap_cnt_q, swap_cnt_d;
    center_t       rd_data_q, rd_data_d;

    logic [IW-1:0] lft_c, rgt_c;
    center_t       l_new_c, p_new_c, r_new_c;
    logic          changed_c;
    logic [7:0]    pass_inc_c;

    assign lft_c      = IW'({par_q, 1'b1});
    assign rgt_c      = IW'({par_q, 1'b0} + (IW+1)'(2));
    assign pass_inc_c = (pass_cnt_q == 8'hFF) ? pass_cnt_q : pass_cnt_q + 8'd1;

    kd_cmp3 u_cmp (
        .axis      (axis_q),
        .l         (nodes_q[lft_c]),
        .p         (nodes_q[par_q]),
        .r         (nodes_q[rgt_c]),
        .l_c       (l_new_c),
        .p_c       (p_new_c),
        .r_c       (r_new_c),
        .changed_c (changed_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            par_q      <= '0;
            axis_q     <= '0;
            dirty_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            pass_cnt_q <= '0;
            swap_cnt_q <= '0;
            rd_data_q  <= '0;
            for (int unsigned i = 0; i < NODES; i++) nodes_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            par_q      <= par_d;
            axis_q     <= axis_d;
            dirty_q    <= dirty_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            pass_cnt_q <= pass_cnt_d;
            swap_cnt_q <= swap_cnt_d;
            rd_data_q  <= rd_data_d;
            nodes_q    <= nodes_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        par_d      = par_q;
        axis_d     = axis_q;
        dirty_d    = dirty_q;
        busy_d     = busy_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        pass_cnt_d = pass_cnt_q;
        swap_cnt_d = swap_cnt_q;
        nodes_d    = nodes_q;
        rd_data_d  = (32'(bus.rd_idx) < NODES) ? nodes_q[bus.rd_idx] : '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.load_en && (32'(bus.load_idx) < NODES))
                    nodes_d[bus.load_idx] = bus.load_data;
                if (bus.start) begin
                    state_d    = ST_FETCH;
                    step_d     = '0;
                    dirty_d    = 1'b0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    timeout_d  = 1'b0;
                    pass_cnt_d = '0;
                    swap_cnt_d = '0;
                end
            end
            ST_FETCH: begin
                par_d   = IW'(sweep_node(32'(step_q)));
                axis_d  = AW'(sweep_axis(32'(step_q)));
                state_d = ST_EXCH;
            end
            ST_EXCH: begin
                nodes_d[lft_c] = l_new_c;
                nodes_d[par_q] = p_new_c;
                nodes_d[rgt_c] = r_new_c;
                if (changed_c) begin
                    dirty_d = 1'b1;
                    if (swap_cnt_q != 16'hFFFF) swap_cnt_d = swap_cnt_q + 16'd1;
                end
                if (step_q == IW'(INTERNAL - 1)) begin
                    state_d = ST_CHECK;
                end else begin
                    step_d  = step_q + IW'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_CHECK: begin
                pass_cnt_d = pass_inc_c;
                dirty_d    = 1'b0;
                step_d     = '0;
                if (!dirty_q) begin
                    state_d = ST_DONE;
                end else if (TO_EN && (pass_inc_c == 8'(MAX_PASSES))) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass_cnt = pass_cnt_q;
    assign bus.swap_cnt = swap_cnt_q;
    assign bus.timeout  = timeout_q;

endmodule
